// File: rtl/tm_queue_depth.sv
// Per-queue depth tracker: FIFO-serialised enq/deq/poll requests run through a read-modify-write pipeline on a 1R1W depth RAM.
// Latency: strobe in cycle N, ack in cycle N+4 when uncontended; one op per cycle in aggregate.
// Backpressure: none; a strobe into a full request FIFO is dropped and sets err_overflow.

module tm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             wr_rdy,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign wr_rdy = (count != (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_rdy && rd_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end
endmodule

module tm_queue_depth #(
    parameter int QID_NBITS      = 12,
    parameter int DEPTH_NBITS    = QID_NBITS + 1,
    parameter int REQ_FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [QID_NBITS:0]   queue_threshold,
    input  logic                 depth_enq_req,
    input  logic [QID_NBITS-1:0] depth_enq_qid,
    input  logic                 depth_deq_req,
    input  logic [QID_NBITS-1:0] depth_deq_qid,
    input  logic                 poll_req,
    input  logic [QID_NBITS-1:0] poll_qid,
    output logic                 depth_enq_ack,
    output logic                 depth_enq_to_empty,
    output logic                 depth_deq_ack,
    output logic                 depth_deq_from_emptyp2,
    output logic                 poll_ack,
    output logic                 poll_drop,
    output logic                 init_done,
    output logic                 err_overflow,
    output logic                 err_underflow
);
    localparam int NQ    = 2**QID_NBITS;
    localparam int CMP_W = (DEPTH_NBITS > QID_NBITS + 1) ? DEPTH_NBITS : QID_NBITS + 1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic [1:0] {OP_DEQ = 2'd0, OP_ENQ = 2'd1, OP_POLL = 2'd2} op_t;

    state_t state, state_nxt;
    logic   init_wr;
    logic   run;
    logic [QID_NBITS-1:0] init_addr;

    logic enq_wr_rdy, deq_wr_rdy, poll_wr_rdy;
    logic enq_vld, deq_vld, poll_vld;
    logic enq_pop, deq_pop, poll_pop;
    logic [QID_NBITS-1:0] enq_fifo_qid, deq_fifo_qid, poll_fifo_qid;
    logic ovf_evt;

    tm_fifo #(.WIDTH(QID_NBITS), .DEPTH(REQ_FIFO_DEPTH)) u_enq_fifo (
        .clk(clk), .rst(rst),
        .wr_vld(depth_enq_req), .wr_dat(depth_enq_qid), .wr_rdy(enq_wr_rdy),
        .rd_vld(enq_vld), .rd_rdy(enq_pop), .rd_dat(enq_fifo_qid)
    );

    tm_fifo #(.WIDTH(QID_NBITS), .DEPTH(REQ_FIFO_DEPTH)) u_deq_fifo (
        .clk(clk), .rst(rst),
        .wr_vld(depth_deq_req), .wr_dat(depth_deq_qid), .wr_rdy(deq_wr_rdy),
        .rd_vld(deq_vld), .rd_rdy(deq_pop), .rd_dat(deq_fifo_qid)
    );

    tm_fifo #(.WIDTH(QID_NBITS), .DEPTH(REQ_FIFO_DEPTH)) u_poll_fifo (
        .clk(clk), .rst(rst),
        .wr_vld(poll_req), .wr_dat(poll_qid), .wr_rdy(poll_wr_rdy),
        .rd_vld(poll_vld), .rd_rdy(poll_pop), .rd_dat(poll_fifo_qid)
    );

    assign ovf_evt = (depth_enq_req && !enq_wr_rdy) ||
                     (depth_deq_req && !deq_wr_rdy) ||
                     (poll_req      && !poll_wr_rdy);

    // Init / run FSM: the clear sweep owns the RAM write port until the last address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            state <= state_nxt;
            if (init_wr) begin
                init_addr <= init_addr + QID_NBITS'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        init_wr   = 1'b0;
        run       = 1'b0;
        case (state)
            ST_INIT: begin
                init_wr = 1'b1;
                if (init_addr == '1) begin
                    state_nxt = ST_RUN;
                end
            end
            default: run = 1'b1;
        endcase
    end

    assign init_done = (state == ST_RUN);

    // Round-robin arbiter; the search starts just after the last winner.
    op_t  last_op;
    op_t  gnt_op;
    logic gnt_vld;
    logic [QID_NBITS-1:0] gnt_qid;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_op  = OP_DEQ;
        if (run) begin
            case (last_op)
                OP_DEQ: begin
                    if      (enq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_ENQ;  end
                    else if (poll_vld) begin gnt_vld = 1'b1; gnt_op = OP_POLL; end
                    else if (deq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_DEQ;  end
                end
                OP_ENQ: begin
                    if      (poll_vld) begin gnt_vld = 1'b1; gnt_op = OP_POLL; end
                    else if (deq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_DEQ;  end
                    else if (enq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_ENQ;  end
                end
                default: begin
                    if      (deq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_DEQ;  end
                    else if (enq_vld)  begin gnt_vld = 1'b1; gnt_op = OP_ENQ;  end
                    else if (poll_vld) begin gnt_vld = 1'b1; gnt_op = OP_POLL; end
                end
            endcase
        end
    end

    assign deq_pop  = gnt_vld && (gnt_op == OP_DEQ);
    assign enq_pop  = gnt_vld && (gnt_op == OP_ENQ);
    assign poll_pop = gnt_vld && (gnt_op == OP_POLL);
    assign gnt_qid  = (gnt_op == OP_DEQ) ? deq_fifo_qid :
                      (gnt_op == OP_ENQ) ? enq_fifo_qid : poll_fifo_qid;

    logic                   s1_vld, s2_vld, s3_wr;
    op_t                    s1_op, s2_op;
    logic [QID_NBITS-1:0]   s1_qid, s2_qid, s3_qid;
    logic [DEPTH_NBITS-1:0] s3_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_op <= OP_POLL;
            s1_vld  <= 1'b0;
            s1_op   <= OP_DEQ;
            s1_qid  <= '0;
            s2_vld  <= 1'b0;
            s2_op   <= OP_DEQ;
            s2_qid  <= '0;
        end else begin
            if (gnt_vld) begin
                last_op <= gnt_op;
            end
            s1_vld <= gnt_vld;
            s1_op  <= gnt_op;
            s1_qid <= gnt_qid;
            s2_vld <= s1_vld;
            s2_op  <= s1_op;
            s2_qid <= s1_qid;
        end
    end

    // Depth RAM: read-old-data when the read and write addresses collide.
    logic [DEPTH_NBITS-1:0] depth_mem [NQ];
    logic [DEPTH_NBITS-1:0] ram_rd;
    logic                   ram_we;
    logic [QID_NBITS-1:0]   ram_wa;
    logic [DEPTH_NBITS-1:0] ram_wd;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            depth_mem[ram_wa] <= ram_wd;
        end
        ram_rd <= depth_mem[s1_qid];
    end

    // The op one ahead commits its write on the same edge this op's read
    // samples the RAM, so its result is taken from the S3 register instead.
    logic [DEPTH_NBITS-1:0] s2_old, s2_new;
    logic                   s2_wr, s2_ovf, s2_unf, s2_drop;

    assign s2_old  = (s3_wr && (s3_qid == s2_qid)) ? s3_dat : ram_rd;
    assign s2_drop = (CMP_W'(s2_old) >= CMP_W'(queue_threshold));

    always_comb begin
        s2_new = s2_old;
        s2_wr  = 1'b0;
        s2_ovf = 1'b0;
        s2_unf = 1'b0;
        if (s2_vld) begin
            case (s2_op)
                OP_ENQ: begin
                    s2_wr = 1'b1;
                    if (s2_old == '1) s2_ovf = 1'b1;
                    else              s2_new = s2_old + DEPTH_NBITS'(1);
                end
                OP_DEQ: begin
                    s2_wr = 1'b1;
                    if (s2_old == '0) s2_unf = 1'b1;
                    else              s2_new = s2_old - DEPTH_NBITS'(1);
                end
                default: ;
            endcase
        end
    end

    assign ram_we = init_wr || s2_wr;
    assign ram_wa = init_wr ? init_addr : s2_qid;
    assign ram_wd = init_wr ? '0 : s2_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_wr                  <= 1'b0;
            s3_qid                 <= '0;
            s3_dat                 <= '0;
            depth_enq_ack          <= 1'b0;
            depth_enq_to_empty     <= 1'b0;
            depth_deq_ack          <= 1'b0;
            depth_deq_from_emptyp2 <= 1'b0;
            poll_ack               <= 1'b0;
            poll_drop              <= 1'b0;
            err_overflow           <= 1'b0;
            err_underflow          <= 1'b0;
        end else begin
            s3_wr                  <= s2_wr;
            s3_qid                 <= s2_qid;
            s3_dat                 <= s2_new;
            depth_enq_ack          <= s2_vld && (s2_op == OP_ENQ);
            depth_enq_to_empty     <= s2_vld && (s2_op == OP_ENQ) && (s2_old == '0);
            depth_deq_ack          <= s2_vld && (s2_op == OP_DEQ);
            depth_deq_from_emptyp2 <= s2_vld && (s2_op == OP_DEQ) && (s2_old >= DEPTH_NBITS'(2));
            poll_ack               <= s2_vld && (s2_op == OP_POLL);
            poll_drop              <= s2_vld && (s2_op == OP_POLL) && s2_drop;
            err_overflow           <= err_overflow || ovf_evt || s2_ovf;
            err_underflow          <= err_underflow || s2_unf;
        end
    end
endmodule

// File: tb/tb_tm_queue_depth.sv
// Directed bench for tm_queue_depth with QID_NBITS=4: init timing, status flags, forwarding, arbitration, error flags.
module tb_tm_queue_depth;
    localparam int QW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [QW:0]   queue_threshold = '0;
    logic          depth_enq_req = 1'b0;
    logic [QW-1:0] depth_enq_qid = '0;
    logic          depth_deq_req = 1'b0;
    logic [QW-1:0] depth_deq_qid = '0;
    logic          poll_req = 1'b0;
    logic [QW-1:0] poll_qid = '0;
    logic depth_enq_ack, depth_enq_to_empty, depth_deq_ack, depth_deq_from_emptyp2;
    logic poll_ack, poll_drop, init_done, err_overflow, err_underflow;

    tm_queue_depth #(.QID_NBITS(QW), .REQ_FIFO_DEPTH(4)) dut (
        .clk(clk),
        .rst(rst),
        .queue_threshold(queue_threshold),
        .depth_enq_req(depth_enq_req),
        .depth_enq_qid(depth_enq_qid),
        .depth_deq_req(depth_deq_req),
        .depth_deq_qid(depth_deq_qid),
        .poll_req(poll_req),
        .poll_qid(poll_qid),
        .depth_enq_ack(depth_enq_ack),
        .depth_enq_to_empty(depth_enq_to_empty),
        .depth_deq_ack(depth_deq_ack),
        .depth_deq_from_emptyp2(depth_deq_from_emptyp2),
        .poll_ack(poll_ack),
        .poll_drop(poll_drop),
        .init_done(init_done),
        .err_overflow(err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit st; int c;} ev_t;
    ev_t enq_q[$];
    ev_t deq_q[$];
    ev_t poll_q[$];
    int  enq_cnt = 0;
    int  stray = 0;
    bit  init_seen = 0;
    int  init_cyc = 0;

    always @(negedge clk) begin
        if (depth_enq_ack) begin enq_q.push_back('{depth_enq_to_empty, cyc}); enq_cnt++; end
        if (depth_deq_ack) deq_q.push_back('{depth_deq_from_emptyp2, cyc});
        if (poll_ack) poll_q.push_back('{poll_drop, cyc});
        if ((!depth_enq_ack && depth_enq_to_empty) || (!depth_deq_ack && depth_deq_from_emptyp2) ||
            (!poll_ack && poll_drop)) stray++;
        if (init_done && !init_seen) begin init_seen = 1; init_cyc = cyc; end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // op: 0 = deq, 1 = enq, 2 = poll
    task automatic get_ev(input int op, input string tag, output bit st, output int c);
        int  sz;
        ev_t e;
        st = 0;
        c  = -1;
        for (int i = 0; i < 100; i++) begin
            sz = (op == 0) ? deq_q.size() : (op == 1) ? enq_q.size() : poll_q.size();
            if (sz > 0) break;
            @(negedge clk); #1;
        end
        sz = (op == 0) ? deq_q.size() : (op == 1) ? enq_q.size() : poll_q.size();
        if (sz == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            case (op)
                0:       e = deq_q.pop_front();
                1:       e = enq_q.pop_front();
                default: e = poll_q.pop_front();
            endcase
            st = e.st;
            c  = e.c;
        end
    endtask

    task automatic issue(input bit e, input int eq, input bit d, input int dq,
                         input bit p, input int pq, output int n);
        @(posedge clk); #1;
        depth_enq_req = e; depth_enq_qid = eq[QW-1:0];
        depth_deq_req = d; depth_deq_qid = dq[QW-1:0];
        poll_req      = p; poll_qid      = pq[QW-1:0];
        n = cyc;
        @(posedge clk); #1;
        depth_enq_req = 0; depth_deq_req = 0; poll_req = 0;
    endtask

    task automatic do_poll(input int qid, input int thr, input bit exp, input string tag);
        int n, c;
        bit st;
        queue_threshold = thr[QW:0];
        issue(0, 0, 0, 0, 1, qid, n);
        get_ev(2, tag, st, c);
        check(tag, st, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0, n, c, n0;
        bit  st;
        bit  exp_te[4];
        bit  exp_fe[3];

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {init_done, depth_enq_ack, depth_enq_to_empty, depth_deq_ack,
              depth_deq_from_emptyp2, poll_ack, poll_drop, err_overflow, err_underflow}, 0);
        rst = 0;
        t0  = cyc;

        // During INIT: 6 enq strobes to qid 11 into a 4-deep FIFO, one poll at cycle 5.
        queue_threshold = 1;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            if (i == 4) check("ovf_before_full", err_overflow, 0);
            depth_enq_req = 1; depth_enq_qid = 11;
            poll_req = (i == 5); poll_qid = 3;
        end
        @(posedge clk); #1;
        depth_enq_req = 0; poll_req = 0;
        repeat (3) @(posedge clk);
        #1;
        check("ovf_sticky", err_overflow, 1);
        check("init_not_done", init_done, 0);

        for (int i = 0; i < 40 && !init_seen; i++) @(posedge clk);
        check("init_cycle", init_cyc - t0, 16);

        exp_te = '{1, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            get_ev(1, "init_enq", st, c);
            check("init_enq_to_empty", st, exp_te[i]);
            if (i == 0) check("init_enq_first_cyc", c - t0, 19);
        end
        get_ev(2, "init_poll", st, c);
        check("init_poll_drop", st, 0);
        check("init_poll_cyc", c - t0, 20);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_ack_count", enq_cnt, 4);

        // Enq/deq status on qid 2.
        for (int i = 0; i < 3; i++) begin
            issue(1, 2, 0, 0, 0, 0, n);
            get_ev(1, "q2_enq", st, c);
            check("q2_enq_to_empty", st, i == 0);
            if (i == 0) check("enq_latency", c - n, 4);
        end
        exp_fe = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            issue(0, 0, 1, 2, 0, 0, n);
            get_ev(0, "q2_deq", st, c);
            check("q2_deq_from_emptyp2", st, exp_fe[i]);
            if (i == 0) check("deq_latency", c - n, 4);
        end
        do_poll(2, 1, 0, "q2_poll_empty");

        // Back-to-back enqs to qid 5 exercise forwarding.
        n0 = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            depth_enq_req = 1; depth_enq_qid = 5;
            if (i == 0) n0 = cyc;
        end
        @(posedge clk); #1;
        depth_enq_req = 0;
        for (int i = 0; i < 4; i++) begin
            get_ev(1, "q5_enq", st, c);
            check("q5_enq_to_empty", st, i == 0);
            if (i == 3) check("q5_last_ack_cyc", c - n0, 7);
        end
        do_poll(5, 4, 1, "q5_poll_thr4");
        do_poll(5, 5, 0, "q5_poll_thr5");

        // Simultaneous strobes on qid 7 at depth 1; last winner is poll so deq goes first.
        issue(1, 7, 0, 0, 0, 0, n);
        get_ev(1, "q7_prep", st, c);
        check("q7_prep_to_empty", st, 1);
        do_poll(7, 1, 1, "q7_poll_d1");
        queue_threshold = 2;
        issue(1, 7, 1, 7, 1, 7, n);
        get_ev(0, "sim_deq", st, c);
        check("sim_deq_from_emptyp2", st, 0);
        check("sim_deq_cyc", c - n, 4);
        get_ev(1, "sim_enq", st, c);
        check("sim_enq_to_empty", st, 1);
        check("sim_enq_cyc", c - n, 5);
        get_ev(2, "sim_poll", st, c);
        check("sim_poll_drop_thr2", st, 0);
        check("sim_poll_cyc", c - n, 6);
        do_poll(7, 1, 1, "q7_final_thr1");

        // Underflow on qid 9.
        check("unf_before", err_underflow, 0);
        issue(0, 0, 1, 9, 0, 0, n);
        get_ev(0, "q9_deq", st, c);
        check("q9_deq_from_emptyp2", st, 0);
        check("unf_sticky", err_underflow, 1);
        do_poll(9, 1, 0, "q9_poll_thr1");
        do_poll(9, 0, 1, "q9_poll_thr0");

        repeat (5) @(posedge clk);
        #1;
        check("status_without_ack", stray, 0);
        check("ovf_still_set", err_overflow, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tm_queue_depth.md
# tm_queue_depth

Per-queue occupancy tracker for the traffic manager. It sits beside the first-level linked-list stage. It answers the linked list's enqueue and dequeue depth requests with empty and ≥2 status, and it answers admission polls by comparing queue depth against the linked list's `queue_threshold`. Depth counters are held in a 1R1W RAM with a read-modify-write pipeline, and requests are serialized through small per-type FIFOs.

## Interface
- `QID_NBITS`, default 12: queue id width; `2**QID_NBITS` queues and depth entries.
- `DEPTH_NBITS`, default `QID_NBITS+1`: depth counter width; saturates at `2**DEPTH_NBITS-1`.
- `REQ_FIFO_DEPTH`, default 4: entries per request FIFO.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `queue_threshold` in `QID_NBITS+1`: admission threshold, sampled at evaluation.
- `depth_enq_req` in 1: enqueue-depth request strobe.
- `depth_enq_qid` in `QID_NBITS`: queue id of the enqueue request.
- `depth_deq_req` in 1: dequeue-depth request strobe.
- `depth_deq_qid` in `QID_NBITS`: queue id of the dequeue request.
- `poll_req` in 1: admission poll strobe.
- `poll_qid` in `QID_NBITS`: queue id of the poll.
- `depth_enq_ack` out 1: enqueue done; one pulse per request, in request order.
- `depth_enq_to_empty` out 1: valid with ack; old depth was 0.
- `depth_deq_ack` out 1: dequeue done; one pulse per request, in order.
- `depth_deq_from_emptyp2` out 1: valid with ack; old depth ≥ 2.
- `poll_ack` out 1: poll done; one pulse per poll, in order.
- `poll_drop` out 1: valid with ack; depth ≥ `queue_threshold`.
- `init_done` out 1: depth RAM clear complete.
- `err_overflow` out 1: sticky; a request FIFO was written while full, or an enqueue hit a saturated counter.
- `err_underflow` out 1: sticky; a dequeue hit depth 0.

## Operation
- **Reset.** All outputs are 0. The FSM enters INIT and writes 0 to every RAM address, one per cycle, with a wrapping address counter.
- **INIT → RUN.** The FSM moves to RUN after address `2**QID_NBITS-1` is written, and `init_done` rises. The FSM has no other transitions; only `rst` returns it to INIT.
- **Requests during INIT.** Requests are captured in their FIFOs but not serviced.
- **Request FIFOs.** There are three FIFOs: enq, deq and poll. A request writes its FIFO on a strobe. A write to a full FIFO drops the request and sets `err_overflow`.
- **Arbiter (RUN only).** Picks at most one non-empty FIFO per cycle, round-robin in the order deq → enq → poll. The last winner drops to lowest priority.
- **S1.** The RAM read address is registered to the selected qid, together with op type.
- **S2.** Read data returns. If S3 is writing the same qid, the S3 write data is forwarded. This gives back-to-back same-qid ops exact results.
- **S2 compute:**
  - enq: `new = old+1`, or `old` with `err_overflow` set if `old` is all ones. `to_empty = (old==0)`.
  - deq: `new = old-1`, or 0 with `err_underflow` set if `old==0`. `from_emptyp2 = (old>=2)`.
  - poll: no write. `drop = ({1'b0,old} >= queue_threshold)`, compared zero-extended to `max(DEPTH_NBITS, QID_NBITS+1)`.
- **S3.** RAM write for enq and deq. Registered acks and status pulse for one cycle.
- **Simultaneous strobes.** Strobes of different types in the same cycle are all accepted. They are serviced in later cycles in arbiter order.
- **Ordering.** Ordering is guaranteed within a type only.
- **Reset mid-operation.** Reset flushes the FIFOs and pipeline. Acks for in-flight requests are lost, and the RAM is re-cleared.

## Timing
- **Uncontended latency.** Strobe at cycle N → ack high in cycle N+4. Cycle N+1 is FIFO non-empty and arbitration, N+2 is S1, N+3 is S2, N+4 is S3.
- **Throughput.** One op per cycle aggregate.
- **Fair share.** Each type gets ≥1 service per 3 cycles under contention.
- **Threshold sampling.** `queue_threshold` is sampled in S2.
- **Write-to-read visibility.** The RAM is read-old-data on same-address read/write. A write in cycle C is visible to a read issued in C+1; a read issued in C is covered by forwarding.
- **`init_done`.** Rises in the cycle after the final clear write, `2**QID_NBITS` cycles after reset release.
- **Output validity.** Status outputs are valid only with their ack and are 0 otherwise.

## Test plan
- **Reset/init:** release `rst`, QID_NBITS=4 → `init_done` at cycle 16. A poll qid 3 strobed at cycle 5 acks after init with `poll_drop=0` at threshold 1.
- **Enq/deq status:** 3 enqs to qid 2, then 3 deqs:
  - `to_empty` = 1,0,0.
  - `from_emptyp2` = 1,1,0.
  - Final poll (threshold 1) → `drop=0`.
- **Back-to-back forwarding:** enq qid 5 on 4 consecutive cycles, then poll with threshold 4 → `drop=1`; with threshold 5 → `drop=0`.
- **Simultaneous strobes:** enq, deq and poll on qid 7 (depth 1) in one cycle → all three acks within cycles N+4..N+6. The deq reports `from_emptyp2` per service order; final depth is 1.
- **Underflow:** deq qid 9 at depth 0 → ack with `from_emptyp2=0`, `err_underflow=1`, depth stays 0.
- **FIFO overflow:** 6 enq strobes during INIT with `REQ_FIFO_DEPTH=4` → `err_overflow=1`; exactly 4 `depth_enq_ack` pulses after `init_done`.
